pe_res_drain: RTL and testbench



---
 rtl/pe_res_drain.sv | 117 +++++++++++
 tb/tb_pe_res_drain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_res_drain.sv
// Result drain for the 3x3 PE: captures a full res_o vector into one of two
// banks (optional ReLU at capture), then streams its words out one per
// handshake while the other bank can accept the next vector.

// Per-word ReLU clamp applied on the capture path.
module pe_res_drain_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         relu_en,
  output logic [W-1:0] dout
);
  assign dout = (relu_en && din[W-1]) ? '0 : din;
endmodule

module pe_res_drain #(
  parameter int OUTPUT_NUM = 9,
  parameter int IW         = 24,
  parameter int FW         = 8,
  parameter int IDXW       = $clog2(OUTPUT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [OUTPUT_NUM*(IW+FW)-1:0]  res_i,
  input  logic                           res_valid_i,
  output logic                           res_ready_o,
  input  logic                           relu_en_i,
  output logic [IW+FW-1:0]               dout_o,
  output logic [IDXW-1:0]                dout_idx_o,
  output logic                           dout_last_o,
  output logic                           dout_valid_o,
  input  logic                           dout_ready_i,
  output logic                           busy_o
);
  localparam int W = IW + FW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(OUTPUT_NUM - 1);

  typedef struct packed {
    logic [W-1:0]    data;
    logic [IDXW-1:0] idx;
    logic            last;
  } word_t;

  logic [OUTPUT_NUM-1:0][W-1:0]      cap_word;
  logic [1:0][OUTPUT_NUM-1:0][W-1:0] bank;
  logic                              wb, rb;
  logic [1:0]                        cnt;
  logic [IDXW-1:0]                   idx;
  logic                              capture, pop, retire;
  word_t                             out_word;

  // One clamp lane per result word, all evaluated in the capture cycle.
  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
    pe_res_drain_lane #(.W(W)) u_lane (
      .din     (res_i[k*W +: W]),
      .relu_en (relu_en_i),
      .dout    (cap_word[k])
    );
  end

  // Ready comes from registered occupancy only, so a full buffer costs one
  // bubble after the retiring pop instead of a combinational ready path.
  assign res_ready_o  = (cnt != 2'd2);
  assign dout_valid_o = (cnt != 2'd0);
  assign busy_o       = (cnt != 2'd0);

  assign capture = res_valid_i && res_ready_o;
  assign pop     = dout_valid_o && dout_ready_i;
  assign retire  = pop && (idx == LAST_IDX);

  assign out_word.data = bank[rb][idx];
  assign out_word.idx  = idx;
  assign out_word.last = (idx == LAST_IDX) && dout_valid_o;

  assign dout_o      = out_word.data;
  assign dout_idx_o  = out_word.idx;
  assign dout_last_o = out_word.last;

  // Bank storage; a capture only ever writes bank[wb], never the draining bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (capture) begin
      bank[wb] <= cap_word;
    end
  end

  // Write/read bank pointers and word index within the draining vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb  <= 1'b0;
      rb  <= 1'b0;
      idx <= '0;
    end else begin
      if (capture) wb <= ~wb;
      if (retire) begin
        idx <= '0;
        rb  <= ~rb;
      end else if (pop) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Occupancy: capture and retire in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
    end else begin
      case ({capture, retire})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_res_drain.sv
// Bench for pe_res_drain: a queue-of-vectors reference model checked every
// cycle, plus directed literal checks and randomized streaming traffic.
module tb_pe_res_drain;
  localparam int N    = 9;
  localparam int W    = 32;
  localparam int IDXW = 4;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*W-1:0]  res_i = '0;
  logic            res_valid_i = 1'b0;
  logic            res_ready_o;
  logic            relu_en_i = 1'b0;
  logic [W-1:0]    dout_o;
  logic [IDXW-1:0] dout_idx_o;
  logic            dout_last_o;
  logic            dout_valid_o;
  logic            dout_ready_i = 1'b0;
  logic            busy_o;

  int n_chk = 0;
  int n_fail = 0;

  pe_res_drain #(.OUTPUT_NUM(N), .IW(24), .FW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_i        (res_i),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .relu_en_i    (relu_en_i),
    .dout_o       (dout_o),
    .dout_idx_o   (dout_idx_o),
    .dout_last_o  (dout_last_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  vec_t mq[$];
  int   mpos = 0;
  logic cap_last = 1'b0;
  logic b2b = 1'b0;
  logic hold_prev = 1'b0;
  logic [W-1:0]    prev_d;
  logic [IDXW-1:0] prev_i;
  logic            prev_l;

  function automatic vec_t apply_relu(input vec_t v, input logic en);
    vec_t r = v;
    for (int k = 0; k < N; k++)
      if (en && $signed(r[k]) < 0) r[k] = '0;
    return r;
  endfunction

  // Compare on the falling edge, then advance the model through the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mpos = 0;
      hold_prev = 1'b0;
      cap_last = 1'b0;
      chk("rst_valid", 32'(dout_valid_o), 32'd0);
      chk("rst_ready", 32'(res_ready_o), 32'd1);
      chk("rst_busy",  32'(busy_o), 32'd0);
      chk("rst_last",  32'(dout_last_o), 32'd0);
      chk("rst_dout",  dout_o, 32'd0);
      chk("rst_idx",   32'(dout_idx_o), 32'd0);
    end else begin
      logic ev, cap, popp;
      ev = (mq.size() > 0);
      chk("valid", 32'(dout_valid_o), 32'(ev));
      chk("busy",  32'(busy_o), 32'(ev));
      chk("ready", 32'(res_ready_o), 32'(mq.size() < 2));
      if (ev) begin
        chk("dout", dout_o, mq[0][mpos]);
        chk("idx",  32'(dout_idx_o), 32'(mpos));
        chk("last", 32'(dout_last_o), 32'(mpos == N-1));
      end else begin
        chk("last_idle", 32'(dout_last_o), 32'd0);
      end
      if (b2b) chk("b2b_nobubble", 32'(dout_valid_o), 32'd1);
      if (hold_prev) begin
        chk("stable_dout", dout_o, prev_d);
        chk("stable_idx",  32'(dout_idx_o), 32'(prev_i));
        chk("stable_last", 32'(dout_last_o), 32'(prev_l));
      end
      cap  = res_valid_i && (mq.size() < 2);
      popp = ev && dout_ready_i;
      hold_prev = ev && !dout_ready_i;
      prev_d = dout_o; prev_i = dout_idx_o; prev_l = dout_last_o;
      cap_last = cap;
      if (popp) begin
        if (mpos == N-1) begin
          void'(mq.pop_front());
          mpos = 0;
        end else begin
          mpos++;
        end
      end
      if (cap) mq.push_back(apply_relu(res_i, relu_en_i));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = $urandom;
    return v;
  endfunction

  // Capture one vector into an empty drain and check each word against literals.
  task automatic drain_literal(input string tag, input vec_t v, input logic relu, input vec_t exp);
    dout_ready_i = 1'b1;
    res_i = v; relu_en_i = relu; res_valid_i = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_pre_valid"}, 32'(dout_valid_o), 32'd0);
    @(posedge clk); #2;
    res_valid_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk); #1;
      chk({tag, "_valid"}, 32'(dout_valid_o), 32'd1);
      chk({tag, "_dout"},  dout_o, exp[k]);
      chk({tag, "_idx"},   32'(dout_idx_o), 32'(k));
      chk({tag, "_last"},  32'(dout_last_o), 32'(k == N-1));
    end
    @(negedge clk); #1;
    chk({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e, a, b;
    logic found;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single vector, no ReLU: word k = (k+1)<<8.
    for (int k = 0; k < N; k++) v[k] = 32'((k + 1) << 8);
    e = {32'h900, 32'h800, 32'h700, 32'h600, 32'h500, 32'h400, 32'h300, 32'h200, 32'h100};
    drain_literal("single", v, 1'b0, e);

    // ReLU on and off with word k = (k-4)<<8.
    for (int k = 0; k < N; k++) v[k] = 32'((k - 4) * 256);
    e = {32'h400, 32'h300, 32'h200, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    drain_literal("relu_on", v, 1'b1, e);
    e = {32'h400, 32'h300, 32'h200, 32'h100, 32'h0,
         32'hFFFFFF00, 32'hFFFFFE00, 32'hFFFFFD00, 32'hFFFFFC00};
    drain_literal("relu_off", v, 1'b0, e);

    // Ping-pong full.
    dout_ready_i = 1'b0;
    a = rand_vec(); b = rand_vec();
    res_i = a; relu_en_i = 1'b0; res_valid_i = 1'b1;
    step();
    res_i = b;
    step();
    res_valid_i = 1'b0;
    @(negedge clk); #1;
    chk("pp_full_ready", 32'(res_ready_o), 32'd0);
    chk("pp_head", dout_o, a[0]);
    @(posedge clk); #2;
    res_i = rand_vec(); res_valid_i = 1'b1;
    repeat (3) step();
    res_valid_i = 1'b0;
    chk("pp_third_rejected_idx", 32'(dout_idx_o), 32'd0);
    dout_ready_i = 1'b1;
    for (int j = 0; j < N; j++) begin
      @(negedge clk); #1;
      chk("pp_ready_low", 32'(res_ready_o), 32'd0);
      chk("pp_a_word", dout_o, a[j]);
    end
    @(negedge clk); #1;
    chk("pp_ready_back", 32'(res_ready_o), 32'd1);
    chk("pp_b_first", dout_o, b[0]);
    @(posedge clk); #2;
    repeat (10) step();

    // Back-to-back: each new capture lands on the previous vector's last pop.
    dout_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      res_i = rand_vec(); relu_en_i = 1'($urandom_range(0, 1)); res_valid_i = 1'b1;
      step();
      res_valid_i = 1'b0;
      if (i == 0) b2b = 1'b1;
      repeat (8) step();
    end
    step();
    b2b = 1'b0;
    repeat (3) step();

    // Random backpressure and random producer for 200 cycles.
    for (int c = 0; c < 200; c++) begin
      dout_ready_i = 1'($urandom_range(0, 1));
      if (!(res_valid_i && !cap_last)) begin
        res_valid_i = ($urandom_range(0, 2) == 0);
        res_i = rand_vec();
        relu_en_i = 1'($urandom_range(0, 1));
      end
      step();
    end
    res_valid_i = 1'b0;
    dout_ready_i = 1'b1;
    repeat (25) step();

    // Reset mid-drain at idx 4 with a second vector pending.
    dout_ready_i = 1'b0;
    res_i = rand_vec(); relu_en_i = 1'b0; res_valid_i = 1'b1;
    step();
    res_i = rand_vec();
    step();
    res_valid_i = 1'b0;
    dout_ready_i = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (dout_idx_o == 4'd4) found = 1'b1;
    end
    chk("rm_reach_idx4", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_valid",  32'(dout_valid_o), 32'd0);
    chk("rm_ready",  32'(res_ready_o), 32'd1);
    chk("rm_busy",   32'(busy_o), 32'd0);
    chk("rm_dout",   dout_o, 32'd0);
    chk("rm_idx",    32'(dout_idx_o), 32'd0);
    chk("rm_last",   32'(dout_last_o), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    v = rand_vec();
    drain_literal("post_reset", v, 1'b0, v);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
